// File: rtl/twos_to_signmag_pkg.sv
// twos_to_signmag_pkg: shared state encoding, default width and counter sizing
package twos_to_signmag_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction
endpackage

// File: rtl/twos_to_signmag_if.sv
// twos_to_signmag_if: operand/result handshake bundle between producer, converter and consumer
interface twos_to_signmag_if
   import twos_to_signmag_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_sign, out_mag, out_valid, busy
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_sign, out_mag, out_valid, busy
   );
endinterface

// File: rtl/twos_to_signmag_serial_negate_cell.sv
// serial_negate_cell: bit-serial copy-until-first-one-then-invert stage
module serial_negate_cell (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic invert_en,
   input  logic b,
   output logic o
);
   logic seen_one;
   always_ff @(posedge clk) begin
      if (reset || clear) seen_one <= 1'b0;
      else if (en && invert_en) seen_one <= seen_one | b;
   end
   assign o = b ^ (invert_en & seen_one);
endmodule

// File: rtl/twos_to_signmag.sv
// twos_to_signmag: bit-serial two's-complement to sign/magnitude converter, LSB first
module twos_to_signmag
   import twos_to_signmag_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic clk,
   input logic reset,
   twos_to_signmag_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);
   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] mag_r;
   logic             sign_r;
   logic [CW-1:0]    cnt;
   logic             o;
   logic             accept;
   assign accept = (state == IDLE) && bus.in_valid;
   serial_negate_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept),
      .en        (state == SHIFT),
      .invert_en (sign_r),
      .b         (shift_reg[0]),
      .o         (o)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         mag_r     <= '0;
         sign_r    <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               shift_reg <= bus.in_data;
               sign_r    <= bus.in_data[WIDTH-1];
               cnt       <= '0;
               state     <= SHIFT;
            end
            SHIFT: begin
               mag_r     <= {o, mag_r[WIDTH-1:1]};
               shift_reg <= shift_reg >> 1;
               cnt       <= cnt + 1'b1;
               state     <= (cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            DONE: state <= bus.out_ready ? IDLE : DONE;
            default: state <= IDLE;
         endcase
      end
   end
   // Results are only visible in DONE; mag_r holds partial data while shifting.
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.out_sign  = (state == DONE) & sign_r;
   assign bus.out_mag   = (state == DONE) ? mag_r : '0;
endmodule
